plab2_mem_test_mem_responder: RTL and testbench

//  Word-addressed test memory that acts as the responder end of the processor's imem/dmem val/rdy ports.

---
 rtl/plab2_mem_test_mem_responder.sv | 149 ++++++++++++++
 tb/tb_plab2_mem_test_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab2_mem_test_mem_responder.sv
// Word-addressed test memory answering val/rdy requests in order after a
// fixed latency, with a response buffer that absorbs backpressure.
module plab2_mem_test_mem_responder #(
    parameter int p_num_words = 256,
    parameter int p_latency   = 2,
    parameter int p_depth     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_msg_type,
    input  logic [31:0] memreq_msg_addr,
    input  logic [31:0] memreq_msg_data,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_msg_type,
    output logic [31:0] memresp_msg_data,
    input  logic        init_en,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data
);

    localparam int AW = $clog2(p_num_words);
    localparam int CW = $clog2(p_depth + 1);
    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int LS = p_latency - 1;
    localparam logic [CW-1:0] DEPTH = CW'(p_depth);
    localparam logic [PW-1:0] LAST = PW'(p_depth - 1);

    logic [31:0] mem [p_num_words];

    logic [AW-1:0] req_idx;
    logic [AW-1:0] init_idx;
    logic [31:0]   req_rdata;
    logic          req_go;
    logic          resp_go;
    logic          push;
    logic          fifo_ne;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;

    logic          pv_q [p_latency];
    logic          pt_q [p_latency];
    logic [31:0]   pd_q [p_latency];

    logic          ft_q [p_depth];
    logic [31:0]   fd_q [p_depth];

    logic unused;
    assign unused = ^{memreq_msg_addr[31:AW+2], memreq_msg_addr[1:0],
                      init_addr[31:AW+2], init_addr[1:0]};

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign req_idx   = memreq_msg_addr[AW+1:2];
    assign init_idx  = init_addr[AW+1:2];
    assign req_rdata = memreq_msg_type ? '0 : mem[req_idx];

    assign memreq_rdy = (count_q < DEPTH);
    assign req_go     = memreq_val && memreq_rdy;
    assign resp_go    = memresp_val && memresp_rdy;
    assign push       = pv_q[LS];
    assign fifo_ne    = (occ_q != '0);

    // Empty buffer lets the pipeline head bypass straight to the port
    always_comb begin
        memresp_val      = 1'b0;
        memresp_msg_type = 1'b0;
        memresp_msg_data = '0;
        if (fifo_ne) begin
            memresp_val      = 1'b1;
            memresp_msg_type = ft_q[rp_q];
            memresp_msg_data = fd_q[rp_q];
        end else if (pv_q[LS]) begin
            memresp_val      = 1'b1;
            memresp_msg_type = pt_q[LS];
            memresp_msg_data = pd_q[LS];
        end
    end

    always_comb begin
        count_d = count_q;
        occ_d   = occ_q;
        wp_d    = push ? wrap_inc(wp_q) : wp_q;
        rp_d    = resp_go ? wrap_inc(rp_q) : rp_q;
        if (req_go && !resp_go) begin
            count_d = count_q + 1'b1;
        end else if (!req_go && resp_go) begin
            count_d = count_q - 1'b1;
        end
        case ({push, resp_go})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            occ_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            for (int i = 0; i < p_latency; i++) begin
                pv_q[i] <= 1'b0;
                pt_q[i] <= 1'b0;
                pd_q[i] <= '0;
            end
            for (int i = 0; i < p_depth; i++) begin
                ft_q[i] <= 1'b0;
                fd_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            occ_q   <= occ_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            pv_q[0] <= req_go;
            pt_q[0] <= memreq_msg_type;
            pd_q[0] <= req_rdata;
            for (int i = 1; i < p_latency; i++) begin
                pv_q[i] <= pv_q[i-1];
                pt_q[i] <= pt_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
            if (push) begin
                ft_q[wp_q] <= pt_q[LS];
                fd_q[wp_q] <= pd_q[LS];
            end
        end
    end

    // Array is never reset; the later init write wins a same-word collision
    always_ff @(posedge clk) begin
        if (req_go && memreq_msg_type) begin
            mem[req_idx] <= memreq_msg_data;
        end
        if (init_en) begin
            mem[init_idx] <= init_data;
        end
    end

endmodule

// File: tb/tb_plab2_mem_test_mem_responder.sv
// Directed bench for the test memory responder: table of single transactions
// plus hand-written back-to-back, backpressure, streaming and reset sequences.
module tb_plab2_mem_test_mem_responder;

    logic        clk;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_msg_type;
    logic [31:0] memreq_msg_addr;
    logic [31:0] memreq_msg_data;
    logic        memresp_val;
    logic        memresp_rdy;
    logic        memresp_msg_type;
    logic [31:0] memresp_msg_data;
    logic        init_en;
    logic [31:0] init_addr;
    logic [31:0] init_data;

    int n_cmp;
    int n_bad;

    plab2_mem_test_mem_responder #(
        .p_num_words(256),
        .p_latency  (2),
        .p_depth    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memreq_msg_type (memreq_msg_type),
        .memreq_msg_addr (memreq_msg_addr),
        .memreq_msg_data (memreq_msg_data),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .memresp_msg_type(memresp_msg_type),
        .memresp_msg_data(memresp_msg_data),
        .init_en         (init_en),
        .init_addr       (init_addr),
        .init_data       (init_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_typ;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic init_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        init_en   = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clk);
        init_en   = 1'b0;
    endtask

    // One isolated request; response must appear exactly two cycles later
    task automatic xfer(input string nm, input logic t, input logic [31:0] a,
                        input logic [31:0] d, input logic et,
                        input logic [31:0] ed);
        @(negedge clk);
        chk({nm, " req_rdy"}, 32'(memreq_rdy), 32'd1);
        memreq_val      = 1'b1;
        memreq_msg_type = t;
        memreq_msg_addr = a;
        memreq_msg_data = d;
        @(negedge clk);
        memreq_val = 1'b0;
        chk({nm, " early_val"}, 32'(memresp_val), 32'd0);
        @(negedge clk);
        chk({nm, " resp_val"}, 32'(memresp_val), 32'd1);
        chk({nm, " resp_type"}, 32'(memresp_msg_type), 32'(et));
        chk({nm, " resp_data"}, memresp_msg_data, ed);
    endtask

    int nacc;
    int nrsp;
    int five_at;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset           = 1'b1;
        memreq_val      = 1'b0;
        memreq_msg_type = 1'b0;
        memreq_msg_addr = '0;
        memreq_msg_data = '0;
        memresp_rdy     = 1'b1;
        init_en         = 1'b0;
        init_addr       = '0;
        init_data       = '0;

        vecs[0] = '{"rd preload", 1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'hCAFE_F00D};
        vecs[1] = '{"wr 2004",    1'b1, 32'h0000_2004, 32'h1234_5678, 1'b1, 32'h0};
        vecs[2] = '{"rd 2004",    1'b0, 32'h0000_2004, 32'h0, 1'b0, 32'h1234_5678};
        vecs[3] = '{"rd 0400",    1'b0, 32'h0000_0400, 32'h0, 1'b0, 32'hCAFE_F00D};
        vecs[4] = '{"rd FFFF0400",1'b0, 32'hFFFF_0400, 32'h0, 1'b0, 32'hCAFE_F00D};
        vecs[5] = '{"rd 0403",    1'b0, 32'h0000_0403, 32'h0, 1'b0, 32'hCAFE_F00D};
        vecs[6] = '{"wr 03FC",    1'b1, 32'h0000_03FC, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[7] = '{"rd 07FC",    1'b0, 32'h0000_07FC, 32'h0, 1'b0, 32'hDEAD_BEEF};

        #1;
        chk("reset req_rdy", 32'(memreq_rdy), 32'd1);
        chk("reset resp_val", 32'(memresp_val), 32'd0);
        chk("reset resp_type", 32'(memresp_msg_type), 32'd0);
        chk("reset resp_data", memresp_msg_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        init_wr(32'h0000_1000, 32'hCAFE_F00D);
        for (int k = 0; k < 6; k++) init_wr(32'h40 + 32'(4 * k), 32'h3000_0000 + 32'(k));
        for (int k = 0; k < 20; k++) init_wr(32'h80 + 32'(4 * k), 32'h5000_0000 + 32'(k));

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].name, vecs[i].typ, vecs[i].addr, vecs[i].data,
                 vecs[i].exp_typ, vecs[i].exp_data);
        end

        // back-to-back write then read of the same word
        @(negedge clk);
        memreq_val      = 1'b1;
        memreq_msg_type = 1'b1;
        memreq_msg_addr = 32'h0000_2008;
        memreq_msg_data = 32'h1111_2222;
        @(negedge clk);
        memreq_msg_type = 1'b0;
        @(negedge clk);
        memreq_val = 1'b0;
        chk("b2b wr val", 32'(memresp_val), 32'd1);
        chk("b2b wr type", 32'(memresp_msg_type), 32'd1);
        chk("b2b wr data", memresp_msg_data, 32'd0);
        @(negedge clk);
        chk("b2b rd val", 32'(memresp_val), 32'd1);
        chk("b2b rd type", 32'(memresp_msg_type), 32'd0);
        chk("b2b rd data", memresp_msg_data, 32'h1111_2222);
        @(negedge clk);
        chk("b2b idle", 32'(memresp_val), 32'd0);

        // backpressure: only four requests fit
        memresp_rdy = 1'b0;
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("bp hold val", 32'(memresp_val), 32'd1);
                chk("bp hold data", memresp_msg_data, 32'h3000_0000);
            end
            memreq_val      = (nacc < 6);
            memreq_msg_type = 1'b0;
            memreq_msg_addr = 32'h40 + 32'(4 * nacc);
            if (memreq_val && memreq_rdy) nacc++;
        end
        chk("bp accepted", 32'(nacc), 32'd4);
        chk("bp full rdy", 32'(memreq_rdy), 32'd0);
        nrsp = 0;
        five_at = -1;
        for (int c = 0; c < 40 && nrsp < 6; c++) begin
            @(negedge clk);
            memresp_rdy = 1'b1;
            if (memresp_val) begin
                chk("bp drain data", memresp_msg_data, 32'h3000_0000 + 32'(nrsp));
                nrsp++;
            end
            memreq_val      = (nacc < 6);
            memreq_msg_addr = 32'h40 + 32'(4 * nacc);
            if (memreq_val && memreq_rdy) begin
                if (nacc == 4) five_at = nrsp;
                nacc++;
            end
        end
        memreq_val = 1'b0;
        chk("bp responses", 32'(nrsp), 32'd6);
        chk("bp total acc", 32'(nacc), 32'd6);
        chk("bp refill after pop", 32'(five_at >= 1), 32'd1);
        repeat (3) @(negedge clk);

        // full-rate stream of 20 reads
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("stream val", 32'(memresp_val), 32'd1);
                chk("stream data", memresp_msg_data, 32'h5000_0000 + 32'(c - 2));
            end
            if (c < 20) begin
                chk("stream rdy", 32'(memreq_rdy), 32'd1);
                memreq_val      = 1'b1;
                memreq_msg_type = 1'b0;
                memreq_msg_addr = 32'h80 + 32'(4 * c);
            end else begin
                memreq_val = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream idle", 32'(memresp_val), 32'd0);

        // same-edge init and write to one word: init wins
        memreq_val      = 1'b1;
        memreq_msg_type = 1'b1;
        memreq_msg_addr = 32'h0000_000C;
        memreq_msg_data = 32'h1111_1111;
        init_en         = 1'b1;
        init_addr       = 32'h0000_000C;
        init_data       = 32'h2222_2222;
        @(negedge clk);
        memreq_val = 1'b0;
        init_en    = 1'b0;
        @(negedge clk);
        chk("conflict wr type", 32'(memresp_msg_type), 32'd1);
        xfer("init wins", 1'b0, 32'h0000_000C, 32'h0, 1'b0, 32'h2222_2222);

        // init after accept does not alter the in-flight read
        init_wr(32'h0000_0010, 32'h0000_0044);
        @(negedge clk);
        memreq_val      = 1'b1;
        memreq_msg_type = 1'b0;
        memreq_msg_addr = 32'h0000_0010;
        @(negedge clk);
        memreq_val = 1'b0;
        init_en    = 1'b1;
        init_addr  = 32'h0000_0010;
        init_data  = 32'h0000_0055;
        @(negedge clk);
        init_en = 1'b0;
        chk("late init val", 32'(memresp_val), 32'd1);
        chk("late init data", memresp_msg_data, 32'h0000_0044);

        // reset with three responses outstanding
        @(negedge clk);
        memresp_rdy     = 1'b0;
        memreq_val      = 1'b1;
        memreq_msg_type = 1'b0;
        memreq_msg_addr = 32'h0000_2004;
        @(negedge clk);
        memreq_msg_addr = 32'h0000_2008;
        @(negedge clk);
        memreq_msg_addr = 32'h0000_03FC;
        @(negedge clk);
        memreq_val = 1'b0;
        @(negedge clk);
        chk("pre-rst val", 32'(memresp_val), 32'd1);
        chk("pre-rst rdy", 32'(memreq_rdy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst val", 32'(memresp_val), 32'd0);
        chk("rst rdy", 32'(memreq_rdy), 32'd1);
        chk("rst data", memresp_msg_data, 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        memresp_rdy = 1'b1;
        xfer("post-rst rd", 1'b0, 32'h0000_2004, 32'h0, 1'b0, 32'h1234_5678);
        xfer("post-rst rd2", 1'b0, 32'h0000_07FC, 32'h0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("final idle", 32'(memresp_val), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
